// File: rtl/regfile_wb_scheduler.sv
// Register file scheduler: issue-side scoreboard with RAW/WAW hazard stalls,
// and a round-robin arbiter sharing the single register file write port
// between the ALU and memory writeback paths.
module regfile_wb_scheduler #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    // issue side
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_rs1,
    input  logic [ADDR_WIDTH-1:0] issue_rs2,
    input  logic [ADDR_WIDTH-1:0] issue_rd,
    output logic                  issue_ready,
    // ALU writeback
    input  logic                  alu_wb_valid,
    input  logic [ADDR_WIDTH-1:0] alu_wb_addr,
    input  logic [DATA_WIDTH-1:0] alu_wb_data,
    output logic                  alu_wb_ready,
    // load writeback
    input  logic                  mem_wb_valid,
    input  logic [ADDR_WIDTH-1:0] mem_wb_addr,
    input  logic [DATA_WIDTH-1:0] mem_wb_data,
    output logic                  mem_wb_ready,
    // register file write port
    output logic                  rf_write_enable,
    output logic [ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    // status
    output logic [NUM_REGS-1:0]   busy,
    output logic [15:0]           stall_count,
    output logic                  wb_error
);

    typedef enum logic {
        PTR_ALU = 1'b0,
        PTR_MEM = 1'b1
    } ptr_e;

    ptr_e                  ptr;
    logic                  issue_fire;
    logic                  alu_grant;
    logic                  mem_grant;
    logic                  grant_valid;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;
    logic [NUM_REGS-1:0]   busy_next;

    // Hazard check: any nonzero source or destination still in flight blocks issue.
    always_comb begin
        issue_ready = !((issue_rs1 != '0) && busy[issue_rs1])
                   && !((issue_rs2 != '0) && busy[issue_rs2])
                   && !((issue_rd  != '0) && busy[issue_rd]);
        issue_fire  = issue_valid && issue_ready;
    end

    // Writeback arbitration: lone requester wins, contention resolved by the pointer.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no
        // path leaves it unassigned, which would otherwise infer a latch.
        alu_grant = 1'b0;
        mem_grant = 1'b0;
        if (!reset) begin
            if (alu_wb_valid && mem_wb_valid) begin
                alu_grant = (ptr == PTR_ALU);
                mem_grant = (ptr == PTR_MEM);
            end else begin
                alu_grant = alu_wb_valid;
                mem_grant = mem_wb_valid;
            end
        end
        grant_valid = alu_grant || mem_grant;
        grant_addr  = alu_grant ? alu_wb_addr : mem_wb_addr;
        grant_data  = alu_grant ? alu_wb_data : mem_wb_data;
    end

    assign alu_wb_ready = alu_grant;
    assign mem_wb_ready = mem_grant;

    // Priority pointer only moves after a contended grant, giving strict alternation.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            ptr <= PTR_ALU;
        end else if (alu_wb_valid && mem_wb_valid) begin
            ptr <= (ptr == PTR_ALU) ? PTR_MEM : PTR_ALU;
        end
    end

    // Write stage: a grant in cycle N drives the register file in N+1; addr/data hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_write_enable <= 1'b0;
            rf_write_addr   <= '0;
            rf_write_data   <= '0;
        end else begin
            rf_write_enable <= grant_valid;
            if (grant_valid) begin
                rf_write_addr <= grant_addr;
                rf_write_data <= grant_data;
            end
        end
    end

    // Scoreboard update: clear on the edge the register file commits, then set on issue (set wins).
    always_comb begin
        busy_next = busy;
        if (rf_write_enable && (rf_write_addr != '0)) begin
            busy_next[rf_write_addr] = 1'b0;
        end
        if (issue_fire && (issue_rd != '0)) begin
            busy_next[issue_rd] = 1'b1;
        end
    end

    // Scoreboard register; bit 0 can never be set because rd=0 is filtered above.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // Sticky error when a writeback is granted to a nonzero register with no write in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_error <= 1'b0;
        end else if (grant_valid && (grant_addr != '0) && !busy[grant_addr]) begin
            wb_error <= 1'b1;
        end
    end

    // Saturating count of cycles in which decode waited on a hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= '0;
        end else if (issue_valid && !issue_ready && (stall_count != 16'hFFFF)) begin
            stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Self-checking bench for regfile_wb_scheduler: directed scenarios plus a
// randomized run, all compared against a behavioural scoreboard model.
module tb_regfile_wb_scheduler;

    localparam int AW = 5;
    localparam int DW = 64;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          issue_valid;
    logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
    logic          issue_ready;
    logic          alu_wb_valid;
    logic [AW-1:0] alu_wb_addr;
    logic [DW-1:0] alu_wb_data;
    logic          alu_wb_ready;
    logic          mem_wb_valid;
    logic [AW-1:0] mem_wb_addr;
    logic [DW-1:0] mem_wb_data;
    logic          mem_wb_ready;
    logic          rf_write_enable;
    logic [AW-1:0] rf_write_addr;
    logic [DW-1:0] rf_write_data;
    logic [NR-1:0] busy;
    logic [15:0]   stall_count;
    logic          wb_error;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    bit            m_busy[NR];
    int            m_stall;
    bit            m_err;
    bit            m_ptr_mem;
    bit            m_wen;
    int unsigned   m_waddr;
    logic [DW-1:0] m_wdata;

    always #5 clk = ~clk;

    regfile_wb_scheduler #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REGS(NR)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
        .issue_rd(issue_rd), .issue_ready(issue_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr),
        .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
        .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr),
        .mem_wb_data(mem_wb_data), .mem_wb_ready(mem_wb_ready),
        .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
        .rf_write_data(rf_write_data), .busy(busy),
        .stall_count(stall_count), .wb_error(wb_error)
    );

    // model: may the presented instruction issue?
    function automatic bit m_ready();
        return !((issue_rs1 != 0 && m_busy[issue_rs1]) ||
                 (issue_rs2 != 0 && m_busy[issue_rs2]) ||
                 (issue_rd  != 0 && m_busy[issue_rd]));
    endfunction

    // model: 0 = no grant, 1 = ALU, 2 = MEM
    function automatic int m_grant();
        if (reset) return 0;
        if (alu_wb_valid && mem_wb_valid) return m_ptr_mem ? 2 : 1;
        if (alu_wb_valid) return 1;
        if (mem_wb_valid) return 2;
        return 0;
    endfunction

    function automatic logic [NR-1:0] m_busy_vec();
        logic [NR-1:0] v;
        for (int i = 0; i < NR; i++) v[i] = m_busy[i];
        return v;
    endfunction

    // advance one clock, updating the model from the inputs presented this cycle
    task automatic tick();
        bit            rdy;
        int            g;
        int unsigned   ga;
        logic [DW-1:0] gd;
        rdy = m_ready();
        g   = m_grant();
        ga  = (g == 1) ? alu_wb_addr : mem_wb_addr;
        gd  = (g == 1) ? alu_wb_data : mem_wb_data;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 0;
            m_stall = 0; m_err = 0; m_ptr_mem = 0;
            m_wen = 0; m_waddr = 0; m_wdata = '0;
        end else begin
            if (g != 0 && ga != 0 && !m_busy[ga]) m_err = 1;
            if (m_wen && m_waddr != 0) m_busy[m_waddr] = 0;
            if (issue_valid && rdy && issue_rd != 0) m_busy[issue_rd] = 1;
            if (issue_valid && !rdy && m_stall < 65535) m_stall++;
            if (alu_wb_valid && mem_wb_valid) m_ptr_mem = !m_ptr_mem;
            m_wen = (g != 0);
            if (g != 0) begin
                m_waddr = ga;
                m_wdata = gd;
            end
        end
        #1;
    endtask

    task automatic idle();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
        alu_wb_valid = 0; alu_wb_addr = 0; alu_wb_data = '0;
        mem_wb_valid = 0; mem_wb_addr = 0; mem_wb_data = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic issue(input int rs1, input int rs2, input int rd);
        issue_valid = 1;
        issue_rs1 = AW'(rs1); issue_rs2 = AW'(rs2); issue_rd = AW'(rd);
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        alu_wb_valid = 1; mem_wb_valid = 1;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b0 || mem_wb_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: alu=%b mem=%b expected 0 0", alu_wb_ready, mem_wb_ready);
        end
        tick();
        tick();
        idle();
        #1;
        checks++;
        if (busy !== '0 || issue_ready !== 1'b1 || rf_write_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: busy=%h ready=%b wen=%b expected 0 1 0", busy, issue_ready, rf_write_enable);
        end
        checks++;
        if (rf_write_addr !== '0 || rf_write_data !== '0 || stall_count !== 16'd0 || wb_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: addr=%0d data=%h stall=%0d err=%b expected all 0",
                     rf_write_addr, rf_write_data, stall_count, wb_error);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_raw_stall();
        do_reset();
        issue(0, 0, 5);
        #1;
        checks++;
        if (issue_ready !== 1'b1) begin
            errors++; $display("FAIL raw_first_ready: got %b expected 1", issue_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (busy[5] !== 1'b1) begin
            errors++; $display("FAIL raw_busy_set: busy=%h expected bit 5 set", busy);
        end
        issue(5, 0, 6);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (issue_ready !== 1'b0) begin
                errors++; $display("FAIL raw_stall_ready: got %b expected 0", issue_ready);
            end
            tick();
            checks++;
            if (stall_count !== 16'(i + 1)) begin
                errors++; $display("FAIL raw_stall_count: got %0d expected %0d", stall_count, i + 1);
            end
        end
        alu_wb_valid = 1; alu_wb_addr = 5; alu_wb_data = 64'hDEAD;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b1) begin
            errors++; $display("FAIL raw_alu_ready: got %b expected 1", alu_wb_ready);
        end
        tick();
        alu_wb_valid = 0;
        #1;
        checks++;
        if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd5 || rf_write_data !== 64'hDEAD) begin
            errors++;
            $display("FAIL raw_rf_write: wen=%b addr=%0d data=%h expected 1 5 dead",
                     rf_write_enable, rf_write_addr, rf_write_data);
        end
        checks++;
        if (issue_ready !== 1'b0) begin
            errors++; $display("FAIL raw_ready_n1: got %b expected 0", issue_ready);
        end
        tick();
        #1;
        checks++;
        if (issue_ready !== 1'b1 || busy[5] !== 1'b0) begin
            errors++; $display("FAIL raw_ready_n2: ready=%b busy=%h expected ready 1, bit 5 clear", issue_ready, busy);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_count !== 16'd5 || busy !== 32'h0000_0040 || wb_error !== 1'b0) begin
            errors++;
            $display("FAIL raw_final: stall=%0d busy=%h err=%b expected 5 00000040 0", stall_count, busy, wb_error);
        end
    endtask

    task automatic test_contention();
        logic [DW-1:0] exp_d;
        logic [AW-1:0] exp_a;
        do_reset();
        alu_wb_valid = 1; alu_wb_addr = 3; alu_wb_data = {$urandom, $urandom};
        mem_wb_valid = 1; mem_wb_addr = 4; mem_wb_data = {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (alu_wb_ready !== (i % 2 == 0) || mem_wb_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL rr_grant[%0d]: alu=%b mem=%b expected %b %b",
                         i, alu_wb_ready, mem_wb_ready, i % 2 == 0, i % 2 == 1);
            end
            exp_a = (i % 2 == 0) ? 5'd3 : 5'd4;
            exp_d = (i % 2 == 0) ? alu_wb_data : mem_wb_data;
            tick();
            checks++;
            if (rf_write_enable !== 1'b1 || rf_write_addr !== exp_a || rf_write_data !== exp_d) begin
                errors++;
                $display("FAIL rr_write[%0d]: wen=%b addr=%0d data=%h expected 1 %0d %h",
                         i, rf_write_enable, rf_write_addr, rf_write_data, exp_a, exp_d);
            end
            if (i % 2 == 0) alu_wb_data = {$urandom, $urandom};
            else            mem_wb_data = {$urandom, $urandom};
        end
        idle();
        tick();
    endtask

    task automatic test_addr_zero();
        do_reset();
        issue(0, 0, 0);
        tick();
        idle();
        #1;
        checks++;
        if (busy !== '0) begin
            errors++; $display("FAIL zero_issue_busy: got %h expected 0", busy);
        end
        mem_wb_valid = 1; mem_wb_addr = 0; mem_wb_data = 64'h0123_4567_89AB_CDEF;
        #1;
        checks++;
        if (mem_wb_ready !== 1'b1) begin
            errors++; $display("FAIL zero_mem_ready: got %b expected 1", mem_wb_ready);
        end
        tick();
        idle();
        #1;
        checks++;
        if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd0 || rf_write_data !== 64'h0123_4567_89AB_CDEF) begin
            errors++;
            $display("FAIL zero_rf_write: wen=%b addr=%0d data=%h expected 1 0 0123456789abcdef",
                     rf_write_enable, rf_write_addr, rf_write_data);
        end
        tick();
        checks++;
        if (busy !== '0 || wb_error !== 1'b0 || rf_write_enable !== 1'b0) begin
            errors++; $display("FAIL zero_after: busy=%h err=%b wen=%b expected 0 0 0", busy, wb_error, rf_write_enable);
        end
    endtask

    task automatic test_wb_error();
        do_reset();
        mem_wb_valid = 1; mem_wb_addr = 7; mem_wb_data = 64'h77;
        tick();
        idle();
        #1;
        checks++;
        if (rf_write_enable !== 1'b1 || rf_write_addr !== 5'd7 || wb_error !== 1'b1) begin
            errors++;
            $display("FAIL err_set: wen=%b addr=%0d err=%b expected 1 7 1", rf_write_enable, rf_write_addr, wb_error);
        end
        repeat (5) tick();
        checks++;
        if (wb_error !== 1'b1) begin
            errors++; $display("FAIL err_sticky: got %b expected 1", wb_error);
        end
        do_reset();
        checks++;
        if (wb_error !== 1'b0) begin
            errors++; $display("FAIL err_reset: got %b expected 0", wb_error);
        end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        issue(0, 0, 2);
        tick();
        issue(0, 0, 11);
        tick();
        issue(2, 0, 0);
        tick();
        tick();
        alu_wb_valid = 1; alu_wb_addr = 2; alu_wb_data = 64'hAA;
        mem_wb_valid = 1; mem_wb_addr = 11; mem_wb_data = 64'hBB;
        tick();
        // ALU won the contended grant; pointer now favours MEM
        reset = 1;
        alu_wb_data = 64'hCC;
        #1;
        checks++;
        if (alu_wb_ready !== 1'b0 || mem_wb_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ready: alu=%b mem=%b expected 0 0", alu_wb_ready, mem_wb_ready);
        end
        tick();
        reset = 0;
        #1;
        checks++;
        if (rf_write_enable !== 1'b0 || busy !== '0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid_state: wen=%b busy=%h stall=%0d expected 0 0 0", rf_write_enable, busy, stall_count);
        end
        checks++;
        if (alu_wb_ready !== 1'b1 || mem_wb_ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ptr: alu=%b mem=%b expected 1 0", alu_wb_ready, mem_wb_ready);
        end
        tick();
        idle();
        tick();
    endtask

    task automatic test_random();
        int g;
        do_reset();
        g = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset = ($urandom_range(0, 299) == 0);
            issue_valid = $urandom_range(0, 1) == 1;
            issue_rs1 = AW'($urandom_range(0, 7));
            issue_rs2 = AW'($urandom_range(0, 7));
            issue_rd  = AW'($urandom_range(0, 7));
            // an ungranted writeback keeps valid/addr/data stable
            if (!alu_wb_valid || g == 1) begin
                alu_wb_valid = $urandom_range(0, 2) != 0;
                alu_wb_addr  = AW'($urandom_range(0, 7));
                alu_wb_data  = {$urandom, $urandom};
            end
            if (!mem_wb_valid || g == 2) begin
                mem_wb_valid = $urandom_range(0, 2) != 0;
                mem_wb_addr  = AW'($urandom_range(0, 7));
                mem_wb_data  = {$urandom, $urandom};
            end
            #1;
            g = m_grant();
            checks++;
            if (issue_ready !== m_ready()) begin
                errors++; $display("FAIL rnd_issue_ready @%0d: got %b expected %b", cyc, issue_ready, m_ready());
            end
            checks++;
            if (alu_wb_ready !== (g == 1) || mem_wb_ready !== (g == 2)) begin
                errors++;
                $display("FAIL rnd_grant @%0d: alu=%b mem=%b expected %b %b", cyc, alu_wb_ready, mem_wb_ready, g == 1, g == 2);
            end
            checks++;
            if (rf_write_enable !== m_wen || rf_write_addr !== AW'(m_waddr) || rf_write_data !== m_wdata) begin
                errors++;
                $display("FAIL rnd_rf_write @%0d: wen=%b addr=%0d data=%h expected %b %0d %h",
                         cyc, rf_write_enable, rf_write_addr, rf_write_data, m_wen, m_waddr, m_wdata);
            end
            checks++;
            if (busy !== m_busy_vec()) begin
                errors++; $display("FAIL rnd_busy @%0d: got %h expected %h", cyc, busy, m_busy_vec());
            end
            checks++;
            if (stall_count !== 16'(m_stall) || wb_error !== m_err) begin
                errors++;
                $display("FAIL rnd_status @%0d: stall=%0d err=%b expected %0d %b", cyc, stall_count, wb_error, m_stall, m_err);
            end
            if (reset) g = 0;
            tick();
        end
        reset = 0;
        idle();
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        issue(0, 0, 9);
        tick();
        issue(9, 0, 0);
        repeat (65534) tick();
        checks++;
        if (stall_count !== 16'hFFFE) begin
            errors++; $display("FAIL sat_before: got %h expected fffe", stall_count);
        end
        repeat (4466) tick();
        checks++;
        if (stall_count !== 16'hFFFF || stall_count !== 16'(m_stall)) begin
            errors++; $display("FAIL sat_hold: got %h expected ffff (model %h)", stall_count, 16'(m_stall));
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        for (int i = 0; i < NR; i++) m_busy[i] = 0;
        m_stall = 0; m_err = 0; m_ptr_mem = 0; m_wen = 0; m_waddr = 0; m_wdata = '0;
        test_reset();
        test_raw_stall();
        test_contention();
        test_addr_zero();
        test_wb_error();
        test_reset_inflight();
        test_random();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_scheduler.md
# regfile_wb_scheduler

Scheduler that sits in front of the integer register file. It tracks pending destination registers in a scoreboard and stalls issue on RAW/WAW hazards. It also shares the register file's single write port between the ALU and memory writeback paths with round-robin arbitration. Issue and decode sit upstream; the ALU and load unit sit downstream.

## Interface
- ADDR_WIDTH, 5, register index width
- DATA_WIDTH, 64, register data width
- NUM_REGS, 32, number of architectural registers (2**ADDR_WIDTH)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- issue_valid  in  1  decode presents an instruction
- issue_rs1, issue_rs2  in  ADDR_WIDTH  source register indices
- issue_rd  in  ADDR_WIDTH  destination index; 0 means no destination
- issue_ready  out  1  instruction may issue this cycle
- alu_wb_valid  in  1  ALU result pending
- alu_wb_addr  in  ADDR_WIDTH  ALU destination
- alu_wb_data  in  DATA_WIDTH  ALU result
- alu_wb_ready  out  1  ALU result accepted this cycle
- mem_wb_valid, mem_wb_addr, mem_wb_data, mem_wb_ready: same as the ALU group, for the load path
- rf_write_enable  out  1  register file write enable
- rf_write_addr  out  ADDR_WIDTH  register file write address
- rf_write_data  out  DATA_WIDTH  register file write data
- busy  out  NUM_REGS  scoreboard; bit i set means register i has a write in flight
- stall_count  out  16  saturating count of cycles with issue_valid && !issue_ready
- wb_error  out  1  sticky; a writeback targeted a non-busy nonzero register

## Operation
- Hazard check (combinational):
  - issue_ready = !(rs1!=0 && busy[rs1]) && !(rs2!=0 && busy[rs2]) && !(rd!=0 && busy[rd]).
  - issue_ready is independent of issue_valid.
- Issue fire = issue_valid && issue_ready.
  - On fire with rd!=0, busy[rd] sets at the clock edge.
  - busy[0] is never set.
- Arbitration between the writeback sources:
  - Only one valid: that source is granted; its ready is asserted the same cycle.
  - Both valid: the source selected by the priority pointer is granted.
  - The pointer flips to the other source only after a contended grant.
  - Reset pointer = ALU.
  - An ungranted source must hold valid, addr and data stable until granted.
- Grant in cycle N:
  - The granted addr and data are registered onto rf_write_*, and rf_write_enable=1 in cycle N+1.
  - With no grant, rf_write_enable=0 in N+1; addr and data hold their previous values.
- Scoreboard clear:
  - busy[addr] clears at the end of cycle N+1, the same edge at which the register file captures the data.
  - A consumer that sees !busy therefore always reads committed data.
- Address 0 writeback: granted and forwarded to rf_write_* (the register file ignores address 0); no scoreboard change; no error.
- Writeback to a nonzero register whose busy bit is 0 at grant: the write still proceeds and wb_error sets. Only reset clears wb_error.
- Set/clear on the same edge for the same register cannot legally occur, because issue requires !busy[rd]. If it does occur, set wins.
- stall_count increments once per stall cycle and saturates at 16'hFFFF.

## Timing
- Reset values:
  - busy=0, issue_ready follows the combinational check (therefore 1), rf_write_enable=0, rf_write_addr=0, rf_write_data=0.
  - alu_wb_ready and mem_wb_ready are 0 during reset.
  - stall_count=0, wb_error=0, pointer=ALU.
- Reset mid-operation discards in-flight grants. rf_write_enable is 0 in the cycle after reset is sampled.
- Issue-to-busy: fire at edge E, busy visible in the cycle after E.
- Writeback latency: a grant in cycle N gives a register file write at the end of N+1. busy drops, and a dependent instruction may issue, in N+2.
- Sustained throughput: one writeback per cycle. With both sources continuously valid, grants alternate ALU, MEM, ALU, ...

## Test plan
- Reset, then issue rd=5 → busy[5]=1 the next cycle. Issue rs1=5 → issue_ready=0 and stall_count increments each cycle. ALU writes back x5=0xDEAD at cycle N → rf_write_enable=1 with addr 5 in N+1; issue_ready=1 in N+2.
- ALU and MEM both valid for 4 cycles, to addrs 3 and 4 → grants ALU, MEM, ALU, MEM. The losing ready is 0 each cycle and the held data is written unchanged.
- Issue rd=0 → busy stays 0. MEM writeback to addr 0 → rf_write_enable=1 with addr 0, wb_error stays 0.
- MEM writeback to addr 7 with busy[7]=0 → write occurs and wb_error=1 until reset.
- Assert reset while a grant is in flight → rf_write_enable=0 the next cycle; busy=0, stall_count=0, pointer=ALU.
- Hold a stall for 70000 cycles → stall_count saturates at 0xFFFF.
